// File: rtl/vga_scanout_if.sv
// Framebuffer read port and VGA pin bundle for vga_scanout.
// The master side is the scanout block; the slave side is the framebuffer
// memory plus the board DAC.
interface vga_scanout_if #(
    parameter int BITS_PER_CHANNEL = 1
);
    logic [14:0]                     mem_addr;
    logic [3*BITS_PER_CHANNEL-1:0]   mem_data;
    logic [7:0]                      VGA_R;
    logic [7:0]                      VGA_G;
    logic [7:0]                      VGA_B;
    logic                            VGA_HS;
    logic                            VGA_VS;
    logic                            VGA_BLANK_N;
    logic                            VGA_SYNC_N;
    logic                            VGA_CLK;
    logic                            frame_start;

    modport master (
        output mem_addr,
        input  mem_data,
        output VGA_R, VGA_G, VGA_B,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
        output frame_start
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        input  VGA_R, VGA_G, VGA_B,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
        input  frame_start
    );
endinterface

// File: rtl/vga_scanout.sv
// 160x120 framebuffer reader driving 640x480@60Hz VGA from a 50 MHz clock.
// Each stored pixel covers a 4x4 block of screen pixels. Counters advance
// every other CLOCK_50 cycle; the memory read sits in the idle half so the
// pins show pixel P two cycles after the counters reach P.
module vga_scanout #(
    parameter int BITS_PER_CHANNEL = 1
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    vga_scanout_if.master bus
);
    localparam int BPC = BITS_PER_CHANNEL;

    localparam logic [9:0] H_LAST      = 10'd799;
    localparam logic [9:0] H_VIS       = 10'd640;
    localparam logic [9:0] H_SYNC_BEG  = 10'd656;
    localparam logic [9:0] H_SYNC_END  = 10'd751;
    localparam logic [9:0] V_LAST      = 10'd524;
    localparam logic [9:0] V_VIS       = 10'd480;
    localparam logic [9:0] V_SYNC_BEG  = 10'd490;
    localparam logic [9:0] V_SYNC_END  = 10'd491;

    // Replicate a channel field across 8 bits so full scale maps to 0xFF.
    function automatic logic [7:0] expand(input logic [BPC-1:0] f);
        return {(8/BPC){f}};
    endfunction

    logic       pix_en_q;
    logic       vga_clk_q;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic       fs_q, fs_d;
    logic       visible;
    logic [7:0] x_c;
    logic [6:0] y_c;

    // Divide-by-two pixel enable and the DAC clock that rises mid-pixel.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pix_en_q  <= 1'b0;
            vga_clk_q <= 1'b0;
        end else begin
            pix_en_q  <= ~pix_en_q;
            vga_clk_q <= ~pix_en_q;
        end
    end

    // Raster position advance: hc wraps at end of line and carries into vc.
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = 10'd0;
            vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
        end
    end

    // Pin values for the pixel the counters currently point at.
    always_comb begin
        visible   = (hc_q < H_VIS) && (vc_q < V_VIS);
        hs_d      = !((hc_q >= H_SYNC_BEG) && (hc_q <= H_SYNC_END));
        vs_d      = !((vc_q >= V_SYNC_BEG) && (vc_q <= V_SYNC_END));
        blank_n_d = visible;
        r_d       = 8'h00;
        g_d       = 8'h00;
        b_d       = 8'h00;
        if (visible) begin
            r_d = expand(bus.mem_data[3*BPC-1:2*BPC]);
            g_d = expand(bus.mem_data[2*BPC-1:BPC]);
            b_d = expand(bus.mem_data[BPC-1:0]);
        end
        // Pulse only on the load edge so it lasts a single CLOCK_50 cycle.
        fs_d = pix_en_q && (hc_q == 10'd0) && (vc_q == 10'd0);
    end

    // Counters and output pins step on edges that close a pix_en=1 cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hc_q      <= 10'd0;
            vc_q      <= 10'd0;
            r_q       <= 8'h00;
            g_q       <= 8'h00;
            b_q       <= 8'h00;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else if (pix_en_q) begin
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
        end
    end

    // frame_start is re-evaluated every cycle so it never stretches to two.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            fs_q <= 1'b0;
        end else begin
            fs_q <= fs_d;
        end
    end

    // Address clamps into the last row/column during blanking so it never
    // leaves the 19200-entry framebuffer.
    always_comb begin
        x_c = (hc_q[9:2] > 8'd159) ? 8'd159 : hc_q[9:2];
        y_c = (vc_q[9:2] > 8'd119) ? 7'd119 : vc_q[8:2];
        bus.mem_addr = {1'b0, y_c, 7'b0} + {3'b0, y_c, 5'b0} + {7'b0, x_c};
    end

    assign bus.VGA_R       = r_q;
    assign bus.VGA_G       = g_q;
    assign bus.VGA_B       = b_q;
    assign bus.VGA_HS      = hs_q;
    assign bus.VGA_VS      = vs_q;
    assign bus.VGA_BLANK_N = blank_n_q;
    assign bus.VGA_SYNC_N  = 1'b0;
    assign bus.VGA_CLK     = vga_clk_q;
    assign bus.frame_start = fs_q;
endmodule
